// File: rtl/mem_rd_arb_pkg.sv
// mem_rd_arb_pkg: shared types for the cache-side read arbiter.
//   rd_type_t    3-bit read request type (byte/half/word/line)
//   arb_state_t  arbiter FSM state
package mem_rd_arb_pkg;

    typedef logic [2:0] rd_type_t;

    localparam rd_type_t RD_TYPE_BYTE = 3'b000;
    localparam rd_type_t RD_TYPE_HALF = 3'b001;
    localparam rd_type_t RD_TYPE_WORD = 3'b010;
    localparam rd_type_t RD_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/rd_arb_pick.sv
// rd_arb_pick: combinational winner select for mem_rd_arbiter.
// Build option: RD_ARB_RR_EN defined -> round-robin search starting at rr_ptr;
//               undefined -> fixed priority, lowest index wins.
// Ports:
//   req     in   NREQ   request vector
//   rr_ptr  in   IDX_W  round-robin search start (ignored in fixed mode)
//   grant   out  NREQ   one-hot grant, zero when no request
//   idx     out  IDX_W  index of the granted requester (0 when none)
module rd_arb_pick
    import mem_rd_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] start;
    logic             found;

`ifdef RD_ARB_RR_EN
    assign start = rr_ptr;
`else
    // Fixed priority is a search that always starts at requester 0.
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
    assign start = '0;
`endif

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned cand;
            cand = (int'(start) + i) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: serialises dcache/icache/MMIO read requests onto the single
// read port of the AXI bridge, one read outstanding at a time, and routes the
// returned beats back to the owning requester.
// Build option: RD_ARB_RR_EN selects round-robin arbitration (default fixed).
// Ports:
//   clk, resetn                      clock, async active-low reset
//   req_valid/req_type/req_addr      per-requester read requests (packed)
//   req_rdy                          request accepted this cycle (IDLE only)
//   ret_valid/ret_last/ret_data      returned beats, routed to owner lane
//   br_rd_req/br_rd_type/br_rd_addr  request to bridge, br_rd_rdy accepts it
//   br_ret_valid/last/data           return beats from bridge
//   busy, owner, beat_err            status; beat_err is sticky
module mem_rd_arbiter
    import mem_rd_arb_pkg::*;
#(
    parameter int unsigned NREQ          = 3,
    parameter int unsigned LINE_WORD_NUM = 4,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned IDX_W         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*3-1:0]      req_type,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_rdy,
    output logic [NREQ-1:0]        ret_valid,
    output logic [NREQ-1:0]        ret_last,
    output logic [31:0]            ret_data,
    output logic                   br_rd_req,
    output logic [2:0]             br_rd_type,
    output logic [ADDR_W-1:0]      br_rd_addr,
    input  logic                   br_rd_rdy,
    input  logic                   br_ret_valid,
    input  logic                   br_ret_last,
    input  logic [31:0]            br_ret_data,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner,
    output logic                   beat_err
);

    localparam int unsigned CNT_W = $clog2(LINE_WORD_NUM) + 1;

    arb_state_t        state_q, state_d;
    rd_type_t          type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  exp_last;
    int unsigned       sel;

    rd_arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (win_idx)
    );

`ifdef RD_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q <= '0;
        end else if (state_q == ARB_IDLE && |req_valid) begin
            rr_ptr_q <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    // Index of the last beat for the latched request type.
    assign exp_last = (type_q == RD_TYPE_LINE) ? CNT_W'(LINE_WORD_NUM - 1) : '0;
    assign sel      = int'(win_idx);

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_rdy   = '0;
        br_rd_req = 1'b0;
        ret_valid = '0;
        ret_last  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    req_rdy = grant;
                    type_d  = req_type[sel*3 +: 3];
                    addr_d  = req_addr[sel*ADDR_W +: ADDR_W];
                    owner_d = win_idx;
                    state_d = ARB_ISSUE;
                end
                // Stray beat: nobody owns it.
                if (br_ret_valid) err_d = 1'b1;
            end
            ARB_ISSUE: begin
                br_rd_req = 1'b1;
                if (br_rd_rdy) begin
                    state_d = ARB_WAIT;
                    cnt_d   = '0;
                end
                if (br_ret_valid) err_d = 1'b1;
            end
            ARB_WAIT: begin
                ret_valid[owner_q] = br_ret_valid;
                ret_last[owner_q]  = br_ret_last;
                if (br_ret_valid) begin
                    if (br_ret_last) begin
                        if (cnt_q != exp_last) err_d = 1'b1;
                        state_d = ARB_IDLE;
                    end else if (cnt_q >= exp_last) begin
                        // Expected last beat arrived without last; keep routing.
                        err_d = 1'b1;
                    end
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            type_q  <= '0;
            addr_q  <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign br_rd_type = type_q;
    assign br_rd_addr = addr_q;
    assign ret_data   = br_ret_data;
    assign busy       = (state_q != ARB_IDLE);
    assign owner      = owner_q;
    assign beat_err   = err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed self-checking bench for mem_rd_arbiter.
// Build option RD_ARB_RR_EN switches the expected grant order of the
// continuous-request sequence to round-robin.
module tb_mem_rd_arbiter;

    logic        clk;
    logic        resetn;
    logic [2:0]  req_valid;
    logic [8:0]  req_type;
    logic [95:0] req_addr;
    logic [2:0]  req_rdy;
    logic [2:0]  ret_valid;
    logic [2:0]  ret_last;
    logic [31:0] ret_data;
    logic        br_rd_req;
    logic [2:0]  br_rd_type;
    logic [31:0] br_rd_addr;
    logic        br_rd_rdy;
    logic        br_ret_valid;
    logic        br_ret_last;
    logic [31:0] br_ret_data;
    logic        busy;
    logic [1:0]  owner;
    logic        beat_err;

    int n_checks;
    int n_fail;

    mem_rd_arbiter #(
        .NREQ          (3),
        .LINE_WORD_NUM (4),
        .ADDR_W        (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_rdy      (req_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data),
        .br_rd_req    (br_rd_req),
        .br_rd_type   (br_rd_type),
        .br_rd_addr   (br_rd_addr),
        .br_rd_rdy    (br_rd_rdy),
        .br_ret_valid (br_ret_valid),
        .br_ret_last  (br_ret_last),
        .br_ret_data  (br_ret_data),
        .busy         (busy),
        .owner        (owner),
        .beat_err     (beat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] t, input logic [31:0] a);
        req_type[i*3 +: 3]  = t;
        req_addr[i*32 +: 32] = a;
        req_valid[i]        = 1'b1;
    endtask

    task automatic accept();
        br_rd_rdy = 1'b1;
        tick();
        br_rd_rdy = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last);
        br_ret_valid = 1'b1;
        br_ret_last  = last;
        br_ret_data  = d;
        #1;
    endtask

    task automatic end_beat();
        tick();
        br_ret_valid = 1'b0;
        br_ret_last  = 1'b0;
        br_ret_data  = '0;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        req_valid    = '0;
        req_type     = '0;
        req_addr     = '0;
        br_rd_rdy    = 1'b0;
        br_ret_valid = 1'b0;
        br_ret_last  = 1'b0;
        br_ret_data  = '0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        // Reset state
        check_eq("rst_busy", busy, 0);
        check_eq("rst_br_rd_req", br_rd_req, 0);
        check_eq("rst_req_rdy", req_rdy, 0);
        check_eq("rst_ret_valid", ret_valid, 0);
        check_eq("rst_beat_err", beat_err, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_br_rd_addr", br_rd_addr, 0);

        // 1: dcache and icache collide, dcache wins, icache right after last
        set_req(0, 3'b010, 32'h1000);
        set_req(1, 3'b010, 32'h2000);
        #1;
        check_eq("t1_req_rdy", req_rdy, 3'b001);
        tick();
        req_valid[0] = 1'b0;
        check_eq("t1_br_rd_req", br_rd_req, 1);
        check_eq("t1_br_rd_addr", br_rd_addr, 32'h1000);
        check_eq("t1_br_rd_type", br_rd_type, 3'b010);
        check_eq("t1_owner", owner, 0);
        check_eq("t1_req_rdy_issue", req_rdy, 0);
        accept();
        drive_beat(32'h55, 1'b1);
        check_eq("t1_ret_valid", ret_valid, 3'b001);
        check_eq("t1_ret_last", ret_last, 3'b001);
        check_eq("t1_ret_data", ret_data, 32'h55);
        check_eq("t1_req_rdy_wait", req_rdy, 0);
        end_beat();
        #1;
        check_eq("t1_icache_rdy", req_rdy, 3'b010);
        check_eq("t1_busy_idle", busy, 0);
        tick();
        req_valid = '0;
        check_eq("t1_icache_addr", br_rd_addr, 32'h2000);
        check_eq("t1_icache_owner", owner, 1);
        accept();
        drive_beat(32'h66, 1'b1);
        check_eq("t1_icache_ret", ret_valid, 3'b010);
        end_beat();
        check_eq("t1_err", beat_err, 0);

        // 2: line read on the MMIO lane, four beats
        set_req(2, 3'b100, 32'h8000_0040);
        tick();
        req_valid = '0;
        check_eq("t2_owner", owner, 2);
        check_eq("t2_type", br_rd_type, 3'b100);
        check_eq("t2_addr", br_rd_addr, 32'h8000_0040);
        accept();
        for (int k = 0; k < 4; k++) begin
            drive_beat(32'hA + k, k == 3);
            check_eq("t2_ret_valid", ret_valid, 3'b100);
            check_eq("t2_ret_last", ret_last, (k == 3) ? 3'b100 : 3'b000);
            check_eq("t2_ret_data", ret_data, 32'hA + k);
            end_beat();
        end
        check_eq("t2_busy", busy, 0);
        check_eq("t2_err", beat_err, 0);

        // 3: word read with last on the second beat
        set_req(0, 3'b010, 32'h100);
        tick();
        req_valid = '0;
        accept();
        drive_beat(32'h1, 1'b0);
        end_beat();
        check_eq("t3_err_beat1", beat_err, 1);
        check_eq("t3_busy_beat1", busy, 1);
        drive_beat(32'h2, 1'b1);
        check_eq("t3_ret_beat2", ret_valid, 3'b001);
        end_beat();
        check_eq("t3_idle", busy, 0);

        // 4: bridge stalls request acceptance for 5 cycles
        do_reset();
        set_req(1, 3'b001, 32'h3004);
        tick();
        req_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            check_eq("t4_req", br_rd_req, 1);
            check_eq("t4_addr", br_rd_addr, 32'h3004);
            check_eq("t4_type", br_rd_type, 3'b001);
            check_eq("t4_req_rdy", req_rdy, 0);
            tick();
        end
        accept();
        req_valid = '0;
        drive_beat(32'h7, 1'b1);
        check_eq("t4_ret", ret_valid, 3'b010);
        end_beat();
        check_eq("t4_busy", busy, 0);

        // 5: reset during beat 2 of a line read, tail beats become stray
        do_reset();
        set_req(0, 3'b100, 32'h40);
        tick();
        req_valid = '0;
        accept();
        drive_beat(32'h1, 1'b0);
        end_beat();
        drive_beat(32'h2, 1'b0);
        check_eq("t5_ret_beat2", ret_valid, 3'b001);
        resetn = 1'b0;
        #1;
        check_eq("t5_busy_rst", busy, 0);
        check_eq("t5_ret_rst", ret_valid, 0);
        tick();
        check_eq("t5_busy_edge", busy, 0);
        resetn = 1'b1;
        check_eq("t5_err_clr", beat_err, 0);
        drive_beat(32'h3, 1'b0);
        check_eq("t5_stray3_ret", ret_valid, 0);
        end_beat();
        check_eq("t5_stray_err", beat_err, 1);
        drive_beat(32'h4, 1'b1);
        check_eq("t5_stray4_ret", ret_valid, 0);
        check_eq("t5_stray4_last", ret_last, 0);
        end_beat();
        check_eq("t5_busy_end", busy, 0);

        // 6: all three requesting continuously
        do_reset();
`ifdef RD_ARB_RR_EN
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
`else
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001; rr_exp[3] = 3'b001;
`endif
        set_req(0, 3'b010, 32'h10);
        set_req(1, 3'b010, 32'h20);
        set_req(2, 3'b010, 32'h30);
        for (int g = 0; g < 4; g++) begin
            #1;
            check_eq("t6_grant", req_rdy, rr_exp[g]);
            tick();
            check_eq("t6_owner_ret", {61'd0, rr_exp[g]}, {61'd0, 3'b001 << owner});
            accept();
            drive_beat(32'h9, 1'b1);
            end_beat();
        end
        check_eq("t6_err", beat_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
